// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the run/pause/abort counter controller.
//   state_t        : 2-bit FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   CNT_WIDTH_DEF  : default width of the count length and running counter
package fsm_counter_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fsm_counter_core.sv
// Counter datapath for fsm_counter_ctrl.
// Holds the terminal value (N-1), the running beat index, and a flag that
// is high when the index has reached the terminal value.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture num_cnt-1 as terminal value and zero the index
//   inc        : advance the index by one
//   clr        : zero the index (terminal value kept for repeat passes)
//   num_cnt    : count length N (non-zero whenever load is high)
//   cnt        : current beat index
//   last       : cnt equals the terminal value
module fsm_counter_core
  import fsm_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 inc,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] num_cnt,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 last
);

  // N-1 is computed once at load, so the per-cycle compare is a plain
  // equality and N=2^CNT_WIDTH-1 terminates before the index could wrap.
  // A cleared register stands for "no length latched".
  logic [CNT_WIDTH-1:0] term_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      term_q <= num_cnt - CNT_WIDTH'(1);
      cnt    <= '0;
    end else if (clr) begin
      cnt    <= '0;
    end else if (inc) begin
      cnt    <= cnt + CNT_WIDTH'(1);
    end
  end

  assign last = (cnt == term_q);

endmodule

// File: rtl/fsm_counter_ctrl.sv
// Run/pause/abort counter controller: "do N beats, then signal done".
// Start handshake: i_run is the valid, o_idle is the ready; a start is
// accepted on a rising clk edge where both are high, and i_num_cnt /
// i_repeat are captured on that same edge. i_run while busy is dropped.
//   clk, reset  : clock, asynchronous active-high reset
//   i_run       : start request (sampled in IDLE only)
//   i_num_cnt   : count length N (0 gives a bare DONE pulse)
//   i_repeat    : auto-reload after each pass
//   i_pause     : level; holds the counter in RUN/PAUSE
//   i_abort     : cancels from any non-IDLE state, highest priority
//   o_idle, o_running, o_paused, o_done : state decodes
//   o_tick      : counter advances this cycle
//   o_cnt       : beat index 0..N-1, zero outside RUN/PAUSE
module fsm_counter_ctrl
  import fsm_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_repeat,
  input  logic                 i_pause,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_paused,
  output logic                 o_done,
  output logic                 o_tick,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  // state_q is the observation point for external checkers.
  state_t               state_q;
  state_t               state_d;
  logic                 rep_q;
  logic                 rep_we;
  logic                 rep_d;
  logic                 load;
  logic                 inc;
  logic                 clr;
  logic                 tick;
  logic                 last;
  logic [CNT_WIDTH-1:0] cnt;

  fsm_counter_core #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .inc     (inc),
    .clr     (clr),
    .num_cnt (i_num_cnt),
    .cnt     (cnt),
    .last    (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rep_we) rep_q <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    tick    = 1'b0;
    rep_we  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          rep_we = 1'b1;
          if (i_num_cnt != '0) begin
            load    = 1'b1;
            rep_d   = i_repeat;
            state_d = ST_RUN;
          end else begin
            // Zero-length start: one DONE pulse, and repeat is forced off
            // so DONE cannot reload a stale length from an earlier run.
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else begin
          tick = 1'b1;
          if (last) begin
            clr     = 1'b1;
            state_d = ST_DONE;
          end else begin
            inc = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (i_abort) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (!i_pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        clr = 1'b1;
        if (!i_abort && rep_q) state_d = ST_RUN;
        else                   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_idle    = (state_q == ST_IDLE);
  assign o_running = (state_q == ST_RUN);
  assign o_paused  = (state_q == ST_PAUSE);
  assign o_done    = (state_q == ST_DONE);
  // The one output that looks at inputs: the tick drops in the very cycle
  // pause or abort is raised, because the counter does not advance then.
  assign o_tick    = tick;
  assign o_cnt     = (o_running || o_paused) ? cnt : '0;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
module tb_fsm_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run = 1'b0;
  logic [15:0] i_num_cnt = '0;
  logic        i_repeat = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_idle, o_running, o_paused, o_done, o_tick;
  logic [15:0] o_cnt;

  logic        run4 = 1'b0;
  logic [3:0]  num4 = '0;
  logic        idle4, running4, paused4, done4, tick4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  fsm_counter_ctrl dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_repeat(i_repeat), .i_pause(i_pause), .i_abort(i_abort),
    .o_idle(o_idle), .o_running(o_running), .o_paused(o_paused),
    .o_done(o_done), .o_tick(o_tick), .o_cnt(o_cnt)
  );

  fsm_counter_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .i_run(run4), .i_num_cnt(num4),
    .i_repeat(1'b0), .i_pause(1'b0), .i_abort(1'b0),
    .o_idle(idle4), .o_running(running4), .o_paused(paused4),
    .o_done(done4), .o_tick(tick4), .o_cnt(cnt4)
  );

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse i_run for one edge; returns just after the accepting edge.
  task automatic start(input int n, input bit rep);
    i_run     = 1'b1;
    i_num_cnt = 16'(n);
    i_repeat  = rep;
    next_cycle();
    i_run     = 1'b0;
    i_repeat  = 1'b0;
  endtask

  // Steps the DUT until o_idle is seen, applying pause/abort/run at given
  // iteration indices (-1 = never), and gathers what the outputs did.
  task automatic measure(input int max_cyc, input int pause_at, input int pause_len,
                         input int abort_at, input int run_at,
                         output int runs, output int ticks, output int dones,
                         output int pauses, output int cnt_bad, output int first_done,
                         output int last_done, output int used, output bit timed_out);
    int idx;
    runs = 0; ticks = 0; dones = 0; pauses = 0; cnt_bad = 0;
    first_done = -1; last_done = -1; used = max_cyc; timed_out = 1'b1; idx = 0;
    for (int c = 0; c < max_cyc; c++) begin
      i_pause = (pause_at >= 0) && (c >= pause_at) && (c < pause_at + pause_len);
      i_abort = (c == abort_at);
      i_run   = (c == run_at);
      #1;
      if (o_idle) begin
        used = c;
        timed_out = 1'b0;
        break;
      end
      if (o_running) runs++;
      if (o_paused) pauses++;
      if (o_tick && !o_running) cnt_bad++;
      if (o_done) begin
        dones++;
        if (first_done < 0) first_done = c;
        last_done = c;
        idx = 0;
        if (o_cnt != 16'd0) cnt_bad++;
      end
      if ((o_running || o_paused) && int'(o_cnt) != idx) cnt_bad++;
      if (o_tick) begin
        ticks++;
        idx++;
      end
      next_cycle();
    end
    i_pause = 1'b0;
    i_abort = 1'b0;
    i_run   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", o_idle); end
    checks++; if ({o_running, o_paused, o_done, o_tick} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {o_running, o_paused, o_done, o_tick}); end
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_cnt); end
    checks++; if (idle4 !== 1'b1) begin errors++; $display("FAIL reset_idle4 got=%b exp=1", idle4); end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    int runs, ticks, dones, pauses, bad, fd, ld, used;
    bit to;
    start(100, 1'b0);
    measure(300, -1, 0, -1, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=timeout exp=idle"); end
    checks++; if (runs != 100) begin errors++; $display("FAIL basic_runs got=%0d exp=100", runs); end
    checks++; if (ticks != 100) begin errors++; $display("FAIL basic_ticks got=%0d exp=100", ticks); end
    checks++; if (dones != 1) begin errors++; $display("FAIL basic_dones got=%0d exp=1", dones); end
    checks++; if (fd != 100) begin errors++; $display("FAIL basic_done_at got=%0d exp=100", fd); end
    checks++; if (used != 101) begin errors++; $display("FAIL basic_idle_at got=%0d exp=101", used); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_cnt_seq got=%0d bad exp=0", bad); end
  endtask

  task automatic test_pause();
    int runs, ticks, dones, pauses, bad, fd, ld, used;
    bit to;
    start(10, 1'b0);
    // i_pause high on iterations 4..8: cnt=4 cycle loses its tick, PAUSE 5 cycles
    measure(100, 4, 5, -1, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (to) begin errors++; $display("FAIL pause_timeout got=timeout exp=idle"); end
    checks++; if (pauses != 5) begin errors++; $display("FAIL pause_cycles got=%0d exp=5", pauses); end
    checks++; if (ticks != 10) begin errors++; $display("FAIL pause_ticks got=%0d exp=10", ticks); end
    checks++; if (runs != 11) begin errors++; $display("FAIL pause_runs got=%0d exp=11", runs); end
    checks++; if (dones != 1 || fd != 16) begin errors++; $display("FAIL pause_done got=%0d@%0d exp=1@16", dones, fd); end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_cnt_held got=%0d bad exp=0", bad); end
  endtask

  task automatic test_abort();
    int runs, ticks, dones, pauses, bad, fd, ld, used;
    bit to;
    start(50, 1'b0);
    measure(100, -1, 0, 20, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (used != 21 || to) begin errors++; $display("FAIL abort_idle_at got=%0d exp=21", used); end
    checks++; if (ticks != 20) begin errors++; $display("FAIL abort_ticks got=%0d exp=20", ticks); end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    checks++; if (o_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnt got=%0d exp=0", o_cnt); end
    start(3, 1'b0);
    measure(100, -1, 0, -1, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (ticks != 3 || runs != 3) begin errors++; $display("FAIL abort_rerun got=%0d/%0d exp=3/3", ticks, runs); end
    checks++; if (dones != 1 || fd != 3 || used != 4) begin errors++; $display("FAIL abort_rerun_done got=%0d@%0d idle@%0d exp=1@3 idle@4", dones, fd, used); end
  endtask

  task automatic test_repeat();
    int runs, ticks, dones, pauses, bad, fd, ld, used;
    bit to;
    start(4, 1'b1);
    i_num_cnt = 16'd9; // must not be re-sampled by the reload
    // RUN 0-3, DONE 4, RUN 5-8, DONE 9, RUN 10-12, abort at 12
    measure(100, -1, 0, 12, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (dones != 2) begin errors++; $display("FAIL repeat_dones got=%0d exp=2", dones); end
    checks++; if (fd != 4 || ld != 9) begin errors++; $display("FAIL repeat_done_at got=%0d,%0d exp=4,9", fd, ld); end
    checks++; if (ticks != 10 || runs != 11) begin errors++; $display("FAIL repeat_ticks got=%0d/%0d exp=10/11", ticks, runs); end
    checks++; if (used != 13 || to) begin errors++; $display("FAIL repeat_abort_idle got=%0d exp=13", used); end
    checks++; if (bad != 0) begin errors++; $display("FAIL repeat_cnt_seq got=%0d bad exp=0", bad); end
  endtask

  task automatic test_edge_lengths();
    int runs, ticks, dones, pauses, bad, fd, ld, used;
    int t4, d4, fd4, bad4, end4;
    bit to;
    start(0, 1'b0);
    measure(20, -1, 0, -1, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (dones != 1 || fd != 0 || ticks != 0 || used != 1) begin errors++; $display("FAIL n0 got=done%0d@%0d ticks%0d idle@%0d exp=done1@0 ticks0 idle@1", dones, fd, ticks, used); end
    start(1, 1'b0);
    measure(20, -1, 0, -1, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (runs != 1 || ticks != 1 || fd != 1 || used != 2) begin errors++; $display("FAIL n1 got=run%0d tick%0d done@%0d idle@%0d exp=run1 tick1 done@1 idle@2", runs, ticks, fd, used); end
    // Maximum length on the 4-bit instance
    num4 = 4'd15;
    run4 = 1'b1;
    next_cycle();
    run4 = 1'b0;
    t4 = 0; d4 = 0; fd4 = -1; bad4 = 0; end4 = -1;
    for (int c = 0; c < 40; c++) begin
      if (idle4) begin end4 = c; break; end
      if (paused4 || (tick4 && !running4)) bad4++;
      if (tick4) begin
        if (int'(cnt4) != t4) bad4++;
        t4++;
      end
      if (done4) begin d4++; if (fd4 < 0) fd4 = c; end
      next_cycle();
    end
    checks++; if (t4 != 15) begin errors++; $display("FAIL nmax_ticks got=%0d exp=15", t4); end
    checks++; if (d4 != 1 || fd4 != 15) begin errors++; $display("FAIL nmax_done got=%0d@%0d exp=1@15", d4, fd4); end
    checks++; if (end4 != 16 || bad4 != 0) begin errors++; $display("FAIL nmax_idle got=idle@%0d bad%0d exp=idle@16 bad0", end4, bad4); end
  endtask

  task automatic test_reset_and_collisions();
    int runs, ticks, dones, pauses, bad, fd, ld, used, extra;
    bit to;
    // i_abort / i_pause in IDLE are ignored
    i_abort = 1'b1; i_pause = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL idle_ignore got=%b exp=1", o_idle); end
    i_abort = 1'b0; i_pause = 1'b0;
    // Async reset between edges
    start(5, 1'b1);
    next_cycle();
    next_cycle();
    #2 reset = 1'b1;
    #1;
    checks++; if (o_idle !== 1'b1 || o_running !== 1'b0 || o_cnt !== 16'd0) begin errors++; $display("FAIL async_reset got=idle%b run%b cnt%0d exp=idle1 run0 cnt0", o_idle, o_running, o_cnt); end
    next_cycle();
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (!o_idle || o_done) extra++;
      next_cycle();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL reset_no_done got=%0d exp=0", extra); end
    // i_run during RUN is ignored
    start(6, 1'b0);
    i_num_cnt = 16'd20;
    measure(100, -1, 0, -1, 2, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (ticks != 6 || fd != 6 || used != 7) begin errors++; $display("FAIL run_ignored got=tick%0d done@%0d idle@%0d exp=tick6 done@6 idle@7", ticks, fd, used); end
    // abort and pause together
    start(8, 1'b0);
    measure(100, 3, 3, 3, -1, runs, ticks, dones, pauses, bad, fd, ld, used, to);
    checks++; if (used != 4 || pauses != 0 || dones != 0 || ticks != 3) begin errors++; $display("FAIL abort_pause got=idle@%0d p%0d d%0d t%0d exp=idle@4 p0 d0 t3", used, pauses, dones, ticks); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_repeat();
    test_edge_lengths();
    test_reset_and_collisions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
